// File: rtl/tx_arb_pkg.sv
// Shared definitions for the two-requester transmit arbiter: state encoding,
// parameter defaults and the timeout counter width helper.
package tx_arb_pkg;

  localparam int          DBIT_DEFAULT      = 8;
  localparam int unsigned TO_CYCLES_DEFAULT = 32'd50000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  // Width able to hold 0 .. cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the transmitter.
// The arbiter connects through the slave modport; the environment uses master.
interface tx_arbiter_if #(
  parameter int DBIT = tx_arb_pkg::DBIT_DEFAULT
);

  logic            req0;
  logic            req1;
  logic [DBIT-1:0] data0;
  logic [DBIT-1:0] data1;
  logic            ack0;
  logic            ack1;
  logic            done0;
  logic            done1;
  logic            tx_start;
  logic [DBIT-1:0] tx_data;
  logic            tx_done;
  logic            busy;
  logic            owner;
  logic            to_err;

  modport slave (
    input  req0, req1, data0, data1, tx_done,
    output ack0, ack1, done0, done1, tx_start, tx_data, busy, owner, to_err
  );

  modport master (
    output req0, req1, data0, data1, tx_done,
    input  ack0, ack1, done0, done1, tx_start, tx_data, busy, owner, to_err
  );

endinterface

// File: rtl/tx_arb_pick.sv
// Two-way grant picker. Round-robin on the pointer by default; defining
// TX_ARB_FIXED_PRIO_EN makes requester 0 always win simultaneous requests.
module tx_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic pointer,
  output logic grant
);

`ifdef TX_ARB_FIXED_PRIO_EN
  // Requester 0 dominates; the pointer is masked off so the port list stays
  // identical across both builds.
  assign grant = ~req0 & (req1 | (pointer & 1'b0));
`else
  assign grant = (req0 & req1) ? pointer : req1;
`endif

endmodule

// File: rtl/tx_arbiter.sv
// Two-requester transmit arbiter: IDLE -> LOAD -> WAIT, one word in flight.
// Optional build macro TX_ARB_FIXED_PRIO_EN selects fixed priority in tx_arb_pick.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int          DBIT      = DBIT_DEFAULT,
  parameter int unsigned TO_CYCLES = TO_CYCLES_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  tx_arbiter_if.slave bus
);

  localparam int            CW      = cnt_width(TO_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 2);

  arb_state_t      state_q, state_d;
  logic [DBIT-1:0] tx_data_q, tx_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            ptr_q, ptr_d;
  logic            done_q, done_d;
  logic            to_err_q, to_err_d;
  logic            pick;

  tx_arb_pick u_pick (
    .req0    (bus.req0),
    .req1    (bus.req1),
    .pointer (ptr_q),
    .grant   (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      done_q    <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      to_err_q  <= to_err_d;
    end
  end

  // The increment that would bring the count to TO_CYCLES-1 is the abort
  // point, so a timed-out word reports done exactly TO_CYCLES clocks after
  // tx_start, the same cycle a tx_done on that last cycle would.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    to_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d   = ST_LOAD;
          owner_d   = pick;
          ptr_d     = ~pick;
          tx_data_d = pick ? bus.data1 : bus.data0;
        end
      end

      ST_LOAD: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        if (bus.tx_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          to_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.tx_start = (state_q == ST_LOAD);
  assign bus.ack0     = bus.tx_start & ~owner_q;
  assign bus.ack1     = bus.tx_start &  owner_q;
  assign bus.done0    = done_q & ~owner_q;
  assign bus.done1    = done_q &  owner_q;
  assign bus.to_err   = to_err_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.owner    = owner_q;

  ack_onehot: assert property (@(posedge clk) disable iff (reset) !(bus.ack0 && bus.ack1));
  done_onehot: assert property (@(posedge clk) disable iff (reset) !(bus.done0 && bus.done1));

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a cycle-count model.
module tb_tx_arbiter;

  localparam int DBIT = 8;
  localparam int TO   = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;

  tx_arbiter_if #(.DBIT(DBIT)) bus ();

  tx_arbiter #(.DBIT(DBIT), .TO_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: outputs for the coming cycle, derived from the request
  // rules and the cycle number of the in-flight word's tx_start.
  bit            m_inflight = 1'b0;
  bit            m_owner    = 1'b0;
  bit            m_last     = 1'b1;
  logic [7:0]    m_tx_data  = 8'h00;
  int            m_cyc      = 0;
  int            m_t0       = 0;
  bit            m_start    = 1'b0;
  bit            m_ack0     = 1'b0;
  bit            m_ack1     = 1'b0;
  bit            m_done0    = 1'b0;
  bit            m_done1    = 1'b0;
  bit            m_to_err   = 1'b0;

  function automatic bit pick_model(input bit r0, input bit r1, input bit last);
    if (r0 && r1) begin
`ifdef TX_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~last;
`endif
    end
    return r1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_inflight = 1'b0;
      m_owner    = 1'b0;
      m_last     = 1'b1;
      m_tx_data  = 8'h00;
      m_start    = 1'b0;
      m_ack0     = 1'b0;
      m_ack1     = 1'b0;
      m_done0    = 1'b0;
      m_done1    = 1'b0;
      m_to_err   = 1'b0;
    end else begin
      m_start  = 1'b0;
      m_ack0   = 1'b0;
      m_ack1   = 1'b0;
      m_done0  = 1'b0;
      m_done1  = 1'b0;
      m_to_err = 1'b0;
      if (!m_inflight) begin
        if (bus.req0 || bus.req1) begin
          m_owner    = pick_model(bus.req0, bus.req1, m_last);
          m_last     = m_owner;
          m_tx_data  = m_owner ? bus.data1 : bus.data0;
          m_inflight = 1'b1;
          m_t0       = m_cyc + 1;
          m_start    = 1'b1;
          m_ack0     = !m_owner;
          m_ack1     = m_owner;
        end
      end else if (m_cyc > m_t0) begin
        if (bus.tx_done || (m_cyc == m_t0 + TO - 1)) begin
          m_inflight = 1'b0;
          m_done0    = !m_owner;
          m_done1    = m_owner;
          m_to_err   = !bus.tx_done;
        end
      end
      m_cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("tx_start", 8'(bus.tx_start), 8'(m_start));
    checkOutput("ack0",     8'(bus.ack0),     8'(m_ack0));
    checkOutput("ack1",     8'(bus.ack1),     8'(m_ack1));
    checkOutput("done0",    8'(bus.done0),    8'(m_done0));
    checkOutput("done1",    8'(bus.done1),    8'(m_done1));
    checkOutput("to_err",   8'(bus.to_err),   8'(m_to_err));
    checkOutput("busy",     8'(bus.busy),     8'(m_inflight));
    checkOutput("owner",    8'(bus.owner),    8'(m_owner));
    checkOutput("tx_data",  bus.tx_data,      m_tx_data);
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the LOAD cycle; returns at its falling edge.
  task automatic waitStart();
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = bus.tx_start;
    end
    if (!seen) checkOutput("start_wait_bound", 8'd0, 8'd1);
  endtask

  task automatic applyStimulus();
    bit exp_grant [4];
`ifdef TX_ARB_FIXED_PRIO_EN
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy",    8'(bus.busy),  8'd0);
    checkOutput("rst_owner",   8'(bus.owner), 8'd0);
    checkOutput("rst_tx_data", bus.tx_data,   8'h00);

    // Single requester 0, finished by tx_done six clocks after tx_start.
    nextCycle(); bus.req0 = 1'b1; bus.data0 = 8'hA5;
    nextCycle(); bus.req0 = 1'b0;
    @(negedge clk);
    checkOutput("a_tx_start", 8'(bus.tx_start), 8'd1);
    checkOutput("a_ack0",     8'(bus.ack0),     8'd1);
    checkOutput("a_tx_data",  bus.tx_data,      8'hA5);
    checkOutput("a_owner",    8'(bus.owner),    8'd0);
    repeat (6) @(posedge clk);
    #1 bus.tx_done = 1'b1;
    nextCycle(); bus.tx_done = 1'b0;
    @(negedge clk);
    checkOutput("a_done0", 8'(bus.done0), 8'd1);
    checkOutput("a_busy",  8'(bus.busy),  8'd0);

    // Requester 1 with no tx_done: abort exactly TO clocks after tx_start.
    nextCycle(); bus.req1 = 1'b1; bus.data1 = 8'h3C;
    nextCycle(); bus.req1 = 1'b0;
    @(negedge clk);
    checkOutput("b_ack1",  8'(bus.ack1),  8'd1);
    checkOutput("b_owner", 8'(bus.owner), 8'd1);
    repeat (TO) @(posedge clk);
    @(negedge clk);
    checkOutput("b_to_err", 8'(bus.to_err), 8'd1);
    checkOutput("b_done1",  8'(bus.done1),  8'd1);
    checkOutput("b_busy",   8'(bus.busy),   8'd0);

    // Both requesters held high: grant order 0,1,0,1 (0,0,0,0 fixed priority).
    nextCycle(); bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data0 = 8'h11; bus.data1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      waitStart();
      checkOutput("c_owner",   8'(bus.owner), 8'(exp_grant[k]));
      checkOutput("c_tx_data", bus.tx_data,   exp_grant[k] ? 8'h22 : 8'h11);
      nextCycle(); bus.tx_done = 1'b1;
      if (k == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      nextCycle(); bus.tx_done = 1'b0;
    end
    repeat (2) nextCycle();

    // tx_done while IDLE and while in LOAD must be ignored.
    bus.tx_done = 1'b1;
    nextCycle(); bus.tx_done = 1'b0;
    @(negedge clk);
    checkOutput("d_idle_done0", 8'(bus.done0), 8'd0);
    checkOutput("d_idle_busy",  8'(bus.busy),  8'd0);
    nextCycle(); bus.req0 = 1'b1; bus.data0 = 8'h5A;
    nextCycle(); bus.req0 = 1'b0; bus.tx_done = 1'b1;
    nextCycle(); bus.tx_done = 1'b0;
    @(negedge clk);
    checkOutput("d_load_busy",  8'(bus.busy),  8'd1);
    checkOutput("d_load_done0", 8'(bus.done0), 8'd0);
    nextCycle(); bus.tx_done = 1'b1;
    nextCycle(); bus.tx_done = 1'b0;
    @(negedge clk);
    checkOutput("d_done0", 8'(bus.done0), 8'd1);

    // Reset three clocks into WAIT aborts silently; req1 then served normally.
    nextCycle(); bus.req1 = 1'b1; bus.data1 = 8'h99;
    nextCycle(); bus.req1 = 1'b0;
    @(negedge clk);
    checkOutput("e_owner_pre", 8'(bus.owner), 8'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("e_async_busy",    8'(bus.busy),     8'd0);
    checkOutput("e_async_owner",   8'(bus.owner),    8'd0);
    checkOutput("e_async_tx_data", bus.tx_data,      8'h00);
    checkOutput("e_async_start",   8'(bus.tx_start), 8'd0);
    nextCycle(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("e_no_done", 8'({bus.done0, bus.done1, bus.to_err}), 8'd0);
    end
    nextCycle(); bus.req1 = 1'b1; bus.data1 = 8'h77;
    waitStart();
    checkOutput("e_ack1",    8'(bus.ack1), 8'd1);
    checkOutput("e_tx_data", bus.tx_data,  8'h77);
    nextCycle(); bus.req1 = 1'b0; bus.tx_done = 1'b1;
    nextCycle(); bus.tx_done = 1'b0;
    repeat (2) nextCycle();

    // Random traffic; requesters hold req until ack and may re-request at once.
    for (int c = 0; c < 1500; c++) begin
      nextCycle();
      if (c == 700) begin
        reset = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0; bus.tx_done = 1'b0;
      end else if (c == 702) begin
        reset = 1'b0;
      end else if (!reset) begin
        if (bus.ack0) bus.req0 = ($urandom_range(3) == 0);
        else if (!bus.req0 && $urandom_range(2) == 0) begin
          bus.req0 = 1'b1; bus.data0 = 8'($urandom);
        end
        if (bus.ack1) bus.req1 = ($urandom_range(3) == 0);
        else if (!bus.req1 && $urandom_range(2) == 0) begin
          bus.req1 = 1'b1; bus.data1 = 8'($urandom);
        end
        bus.tx_done = ($urandom_range(3) == 0);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.tx_done = 1'b0;
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("drain_busy", 8'(bus.busy), 8'd0);
  endtask

  initial begin
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    bus.data0   = '0;
    bus.data1   = '0;
    bus.tx_done = 1'b0;
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
